// File: rtl/duft_test_sequencer.sv
// Host-side sequencer for one DUFT: applies a vector, captures the result, optionally streams a
// scan dump, and returns everything through a result FIFO ending in a status trailer.
// Optional build macro DUFT_SEQ_TIMEOUT_EN adds a per-wait-state watchdog.
module duft_test_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        cmd_dump,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output logic        dut_val_op,
  output logic        dut_commit_ack,
  input  logic        dut_op_ack,
  input  logic        dut_op_commit,
  output logic        dft_val_op,
  output logic        dft_commit_ack,
  output logic        ex_sen,
  input  logic        dft_op_ack,
  input  logic        dft_op_commit,
  input  logic        dft_output_strobe,
  input  logic [31:0] dft_out,
  output logic [2:0]  fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the payload stays stable until the transfer.

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DUT_REQ    = 3'd1,
    DUT_WAIT   = 3'd2,
    DUT_PUSH   = 3'd3,
    DFT_REQ    = 3'd4,
    DFT_STREAM = 3'd5,
    TRAILER    = 3'd6
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t        state, state_n;
  logic          dump_q, dumped, ovf, tmo, tmo_hit;
  logic [31:0]   result_q;
  logic [15:0]   wcount;
  logic          accept, push, pop, full, can_push;
  logic [32:0]   push_word;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign full      = (count == (AW + 1)'(FIFO_DEPTH));
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign can_push  = !full || res_ready;
  assign res_data  = res_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign res_last  = res_valid && mem[rd_ptr][32];
  assign fsm_state = state;

`ifdef DUFT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == DUT_REQ) || (state == DUT_WAIT) ||
                   (state == DFT_REQ) || (state == DFT_STREAM);
  assign tmo_hit = waiting && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      wait_cnt <= (state_n != state || !waiting) ? '0 : wait_cnt + 1'b1;
      if (accept)       tmo <= 1'b0;
      else if (tmo_hit) tmo <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_word = '0;
    case (state)
      IDLE:     if (accept) state_n = DUT_REQ;
      DUT_REQ:  if (tmo_hit) state_n = TRAILER; else if (dut_op_ack) state_n = DUT_WAIT;
      DUT_WAIT: if (tmo_hit) state_n = TRAILER; else if (dut_op_commit) state_n = DUT_PUSH;
      DUT_PUSH: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = {1'b0, result_q};
          state_n   = dump_q ? DFT_REQ : TRAILER;
        end
      end
      DFT_REQ:  if (tmo_hit) state_n = TRAILER; else if (dft_op_ack) state_n = DFT_STREAM;
      DFT_STREAM: begin
        // A strobe coinciding with commit is still pushed before leaving the stream.
        if (dft_output_strobe && can_push) begin
          push      = 1'b1;
          push_word = {1'b0, dft_out};
        end
        if (tmo_hit || dft_op_commit) state_n = TRAILER;
      end
      TRAILER: begin
        if (can_push) begin
          push      = 1'b1;
          push_word = {1'b1, ovf, tmo, dumped, 13'd0, wcount};
          state_n   = IDLE;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      data_in        <= '0;
      dump_q         <= 1'b0;
      dumped         <= 1'b0;
      ovf            <= 1'b0;
      wcount         <= '0;
      result_q       <= '0;
      dut_val_op     <= 1'b0;
      dut_commit_ack <= 1'b0;
      dft_val_op     <= 1'b0;
      dft_commit_ack <= 1'b0;
      ex_sen         <= 1'b0;
    end else begin
      state          <= state_n;
      cmd_ready      <= (state_n == IDLE);
      dut_val_op     <= (state_n == DUT_REQ);
      dft_val_op     <= (state_n == DFT_REQ);
      ex_sen         <= (state_n == DFT_REQ) || (state_n == DFT_STREAM);
      dut_commit_ack <= (state == DUT_WAIT) && dut_op_commit && !tmo_hit;
      dft_commit_ack <= (state == DFT_STREAM) && dft_op_commit && !tmo_hit;
      if (accept) begin
        data_in <= cmd_data;
        dump_q  <= cmd_dump;
        dumped  <= 1'b0;
        ovf     <= 1'b0;
        wcount  <= '0;
      end
      if (state == DUT_WAIT && dut_op_commit && !tmo_hit) result_q <= data_out;
      if (state == DUT_PUSH && state_n == DFT_REQ) dumped <= 1'b1;
      if (state == DFT_STREAM && dft_output_strobe) begin
        if (wcount != 16'hFFFF) wcount <= wcount + 16'd1;
        if (!can_push) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_duft_test_sequencer.sv
// Randomized bench for duft_test_sequencer: a transaction-level model predicts the result stream
// (result word, kept dump words, trailer) from the capacity and status rules.
module tb_duft_test_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0, reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_dump = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        res_valid, res_ready = 1'b0, res_last;
  logic [31:0] res_data, data_in, data_out = '0, dft_out = '0;
  logic        dut_val_op, dut_commit_ack, dut_op_ack = 1'b0, dut_op_commit = 1'b0;
  logic        dft_val_op, dft_commit_ack, ex_sen;
  logic        dft_op_ack = 1'b0, dft_op_commit = 1'b0, dft_output_strobe = 1'b0;
  logic [2:0]  fsm_state;

  duft_test_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dump(cmd_dump), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .data_in(data_in), .data_out(data_out),
    .dut_val_op(dut_val_op), .dut_commit_ack(dut_commit_ack), .dut_op_ack(dut_op_ack),
    .dut_op_commit(dut_op_commit), .dft_val_op(dft_val_op), .dft_commit_ack(dft_commit_ack),
    .ex_sen(ex_sen), .dft_op_ack(dft_op_ack), .dft_op_commit(dft_op_commit),
    .dft_output_strobe(dft_output_strobe), .dft_out(dft_out), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] words[$];
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- host side: ready driver and scoreboard ----------------
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() != 0) check("res_word", 64'({res_last, res_data}), 64'(exp_q.pop_front()));
      else check("res_word_extra", 64'(exp_q.size()), 64'd1);
    end
  end

  // Transaction-level model: result word, then the dump words that fit behind it, then trailer.
  task automatic model_txn(input logic [31:0] r, input logic dmp, input int n);
    int kept;
    kept = (n > DEPTH - 1) ? DEPTH - 1 : n;
    exp_q.push_back({1'b0, r});
    if (dmp) for (int i = 0; i < kept; i++) exp_q.push_back({1'b0, words[i]});
    exp_q.push_back({1'b1, 1'(n > kept), 1'b0, dmp, 13'd0, 16'(n)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] d, input logic dmp);
    int k = 0;
    cmd_valid = 1'b1; cmd_data = d; cmd_dump = dmp;
    while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_dump = 1'b0;
    @(negedge clk);
    check("dut_val_op_rise", 64'(dut_val_op), 64'd1);
    check("data_in", 64'(data_in), 64'(d));
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic do_dut(input logic [31:0] r, input int ack_dly, input int cmt_dly);
    repeat (ack_dly) @(posedge clk);
    #1;
    check("dut_val_op_hold", 64'(dut_val_op), 64'd1);
    dut_op_ack = 1'b1;
    @(posedge clk); #1;
    dut_op_ack = 1'b0;
    @(negedge clk);
    check("dut_val_op_fall", 64'(dut_val_op), 64'd0);
    repeat (cmt_dly) @(posedge clk);
    #1;
    dut_op_commit = 1'b1; data_out = r;
    @(posedge clk); #1;
    dut_op_commit = 1'b0; data_out = $urandom;
    @(negedge clk);
    check("dut_commit_ack_pulse", 64'(dut_commit_ack), 64'd1);
    check("ex_sen_low_dut", 64'(ex_sen), 64'd0);
    @(negedge clk);
    check("dut_commit_ack_end", 64'(dut_commit_ack), 64'd0);
  endtask

  task automatic dft_start(input int ack_dly);
    int k = 0;
    while (!dft_val_op && k < 50) begin @(negedge clk); k++; end
    check("dft_val_op_rise", 64'(dft_val_op), 64'd1);
    check("ex_sen_rise", 64'(ex_sen), 64'd1);
    repeat (ack_dly) @(posedge clk);
    #1;
    dft_op_ack = 1'b1;
    @(posedge clk); #1;
    dft_op_ack = 1'b0;
    @(negedge clk);
    check("dft_val_op_fall", 64'(dft_val_op), 64'd0);
    check("ex_sen_stream", 64'(ex_sen), 64'd1);
  endtask

  task automatic do_dft(input int ack_dly, input logic same, input logic gaps);
    int n;
    n = words.size();
    dft_start(ack_dly);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        dft_output_strobe = 1'b0;
        @(posedge clk); #1;
      end
      dft_output_strobe = 1'b1; dft_out = words[i];
      dft_op_commit = same && (i == n - 1);
      @(posedge clk); #1;
    end
    dft_output_strobe = 1'b0; dft_out = $urandom;
    if (!same || n == 0) begin
      dft_op_commit = 1'b1;
      @(posedge clk); #1;
    end
    dft_op_commit = 1'b0;
    @(negedge clk);
    check("dft_commit_ack_pulse", 64'(dft_commit_ack), 64'd1);
    check("ex_sen_fall", 64'(ex_sen), 64'd0);
    @(negedge clk);
    check("dft_commit_ack_end", 64'(dft_commit_ack), 64'd0);
  endtask

  task automatic run_txn(input logic [31:0] d, input logic [31:0] r, input logic dmp,
                         input int ack1, input int cmt, input int ack2,
                         input logic same, input logic gaps);
    model_txn(r, dmp, words.size());
    send_cmd(d, dmp);
    do_dut(r, ack1, cmt);
    if (dmp) do_dft(ack2, same, gaps);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(negedge clk); k++; end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("fifo_empty_after_drain", 64'(res_valid), 64'd0);
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b0;
    dut_op_ack = 1'b0; dut_op_commit = 1'b0; dft_op_ack = 1'b0;
    dft_op_commit = 1'b0; dft_output_strobe = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_outs"}, 64'({cmd_ready, res_valid, res_last, dut_val_op, dut_commit_ack,
                                dft_val_op, dft_commit_ack, ex_sen, fsm_state}), 64'd0);
    check({tag, "_data"}, 64'({res_data, data_in}), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        dmp;
    logic [31:0] rnd_d, rnd_r;
    int          k;
    repeat (2) @(posedge clk);
    reset_and_check("reset");

    // no-dump command
    ready_mode = 0;
    words.delete();
    run_txn(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 2, 1, 0, 1'b0, 1'b0);
    wait_drain();

    // dump of four words, commit alongside the last strobe
    words = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_txn(32'h0000_0F0F, 32'hC0DE_0001, 1'b1, 0, 0, 1, 1'b1, 1'b0);
    wait_drain();

    // a command presented while busy waits for the trailer
    words.delete();
    model_txn(32'h3333_4444, 1'b0, 0);
    send_cmd(32'h1111_2222, 1'b0);
    cmd_valid = 1'b1; cmd_data = 32'h5555_6666; cmd_dump = 1'b1;
    do_dut(32'h3333_4444, 1, 1);
    k = 0;
    while (!cmd_ready && k < 50) begin
      check("busy_data_in_hold", 64'(data_in), 64'h1111_2222);
      @(negedge clk); k++;
    end
    check("busy_not_taken", 64'(data_in), 64'h1111_2222);
    words = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    run_txn(32'h5555_6666, 32'h7777_8888, 1'b1, 1, 2, 0, 1'b0, 1'b1);
    wait_drain();

    // randomized transactions with random host backpressure
    ready_mode = 1;
    for (int t = 0; t < 24; t++) begin
      dmp = 1'($urandom_range(0, 1));
      rnd_d = $urandom; rnd_r = $urandom;
      words.delete();
      if (dmp) repeat ($urandom_range(0, DEPTH - 1)) words.push_back($urandom);
      run_txn(rnd_d, rnd_r, dmp, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    // overflow: host stalled, ten strobes into an eight-entry FIFO
    ready_mode = 2;
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back(32'hD000_0000 + 32'(i));
    run_txn(32'h0BAD_F00D, 32'h0000_BEEF, 1'b1, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("ovf_trailer_blocked", 64'(cmd_ready), 64'd0);
    check("ovf_fifo_full_head", 64'({res_valid, res_last, res_data}), 64'({2'b10, 32'h0000_BEEF}));
    ready_mode = 0;
    wait_drain();

`ifdef DUFT_SEQ_TIMEOUT_EN
    // watchdog: the DUT never acknowledges
    exp_q.push_back({1'b1, 32'h4000_0000});
    send_cmd(32'hCAFE_0001, 1'b0);
    k = 0;
    while (dut_val_op && k < 100) begin k++; @(negedge clk); end
    check("tmo_val_op_cycles", 64'(k), 64'(TMO));
    wait_drain();
`endif

    // reset in the middle of a dump stream
    ready_mode = 2;
    words.delete();
    send_cmd(32'h1357_9BDF, 1'b1);
    do_dut(32'h2468_ACE0, 0, 0);
    dft_start(0);
    for (int i = 0; i < 2; i++) begin
      dft_output_strobe = 1'b1; dft_out = $urandom;
      @(posedge clk); #1;
    end
    check("mid_stream_busy", 64'({res_valid, ex_sen}), 64'b11);
    reset_and_check("reset_mid");

    // normal operation after the mid-stream reset
    ready_mode = 0;
    words = '{32'hFEED_0001};
    run_txn(32'h9999_0000, 32'h8888_0000, 1'b1, 1, 1, 1, 1'b0, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
